// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU operand stage.
// Holds datapath widths, ALU opcodes and the stage payload struct.
package alu_pkg;

    localparam int XLEN = 32;
    localparam int REGW = 5;

    localparam logic [3:0] ALU_MUL    = 4'b0000;
    localparam logic [3:0] ALU_DIV    = 4'b0001;
    localparam logic [3:0] ALU_OR     = 4'b0010;
    localparam logic [3:0] ALU_OR_ALT = 4'b0011;
    localparam logic [3:0] ALU_XOR    = 4'b0100;
    localparam logic [3:0] ALU_SLL    = 4'b0101;
    localparam logic [3:0] ALU_SRL    = 4'b0110;
    localparam logic [3:0] ALU_SRA    = 4'b0111;
    localparam logic [3:0] ALU_SLT    = 4'b1000;
    localparam logic [3:0] ALU_SLTU   = 4'b1001;
    localparam logic [3:0] ALU_NOP    = 4'b1111;

    typedef struct packed {
        logic            valid;
        logic [REGW-1:0] rs1;
        logic [REGW-1:0] rs2;
        logic [REGW-1:0] rd;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic            use_imm;
        logic [3:0]      alu_op;
        logic            reg_write;
    } stage_t;

    function automatic stage_t bubble();
        stage_t s;
        s        = '0;
        s.alu_op = ALU_NOP;
        return s;
    endfunction

endpackage

// File: rtl/alu_operand_stage_if.sv
// Decode/hazard/forwarding bundle into the operand stage and its ALU-side outputs.
// master drives decode, hazard and forwarding inputs; slave is the stage.
interface alu_operand_stage_if;
    import alu_pkg::*;

    logic            stall;
    logic            flush;
    logic            in_valid;
    logic [REGW-1:0] in_rs1;
    logic [REGW-1:0] in_rs2;
    logic [REGW-1:0] in_rd;
    logic [XLEN-1:0] in_rs1_data;
    logic [XLEN-1:0] in_rs2_data;
    logic [XLEN-1:0] in_imm;
    logic            in_use_imm;
    logic [3:0]      in_alu_op;
    logic            in_reg_write;
    logic            exm_reg_write;
    logic [REGW-1:0] exm_rd;
    logic [XLEN-1:0] exm_result;
    logic            wb_reg_write;
    logic [REGW-1:0] wb_rd;
    logic [XLEN-1:0] wb_result;
    logic            ex_valid;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [3:0]      alu_op;
    logic [REGW-1:0] ex_rd;
    logic            ex_reg_write;
    logic [XLEN-1:0] ex_store_data;

    modport master (
        output stall, flush, in_valid,
        output in_rs1, in_rs2, in_rd,
        output in_rs1_data, in_rs2_data, in_imm,
        output in_use_imm, in_alu_op, in_reg_write,
        output exm_reg_write, exm_rd, exm_result,
        output wb_reg_write, wb_rd, wb_result,
        input  ex_valid, alu_a, alu_b, alu_op,
        input  ex_rd, ex_reg_write, ex_store_data
    );

    modport slave (
        input  stall, flush, in_valid,
        input  in_rs1, in_rs2, in_rd,
        input  in_rs1_data, in_rs2_data, in_imm,
        input  in_use_imm, in_alu_op, in_reg_write,
        input  exm_reg_write, exm_rd, exm_result,
        input  wb_reg_write, wb_rd, wb_result,
        output ex_valid, alu_a, alu_b, alu_op,
        output ex_rd, ex_reg_write, ex_store_data
    );

endinterface

// File: rtl/operand_fwd_mux.sv
// Per-operand bypass select: EX/MEM beats WB beats the stored value.
// Register x0 is hardwired, so it never takes a bypass.
module operand_fwd_mux
    import alu_pkg::*;
(
    input  logic [REGW-1:0] i_rs,
    input  logic [XLEN-1:0] i_stored,
    input  logic            i_exm_reg_write,
    input  logic [REGW-1:0] i_exm_rd,
    input  logic [XLEN-1:0] i_exm_result,
    input  logic            i_wb_reg_write,
    input  logic [REGW-1:0] i_wb_rd,
    input  logic [XLEN-1:0] i_wb_result,
    output logic [XLEN-1:0] o_value
);

    logic w_nz;
    logic w_hit_exm;
    logic w_hit_wb;

    assign w_nz      = |i_rs;
    assign w_hit_exm = w_nz && i_exm_reg_write && (i_exm_rd == i_rs);
    assign w_hit_wb  = w_nz && i_wb_reg_write && (i_wb_rd == i_rs);

    always_comb begin
        o_value = i_stored;
        if (w_hit_exm)
            o_value = i_exm_result;
        else if (w_hit_wb)
            o_value = i_wb_result;
    end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX pipeline register with RAW forwarding, stall hold and flush bubble.
// Drives the ALU operands and opcode directly.
module alu_operand_stage
    import alu_pkg::*;
(
    input logic               clk,
    input logic               rst,
    alu_operand_stage_if.slave bus
);

    stage_t          r_stage;
    logic [XLEN-1:0] w_fwd1;
    logic [XLEN-1:0] w_fwd2;

    operand_fwd_mux u_fwd_rs1 (
        .i_rs            (r_stage.rs1),
        .i_stored        (r_stage.rs1_data),
        .i_exm_reg_write (bus.exm_reg_write),
        .i_exm_rd        (bus.exm_rd),
        .i_exm_result    (bus.exm_result),
        .i_wb_reg_write  (bus.wb_reg_write),
        .i_wb_rd         (bus.wb_rd),
        .i_wb_result     (bus.wb_result),
        .o_value         (w_fwd1)
    );

    operand_fwd_mux u_fwd_rs2 (
        .i_rs            (r_stage.rs2),
        .i_stored        (r_stage.rs2_data),
        .i_exm_reg_write (bus.exm_reg_write),
        .i_exm_rd        (bus.exm_rd),
        .i_exm_result    (bus.exm_result),
        .i_wb_reg_write  (bus.wb_reg_write),
        .i_wb_rd         (bus.wb_rd),
        .i_wb_result     (bus.wb_result),
        .o_value         (w_fwd2)
    );

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            r_stage <= bubble();
        end else if (bus.stall) begin
            // capture bypassed values so a producer leaving WB is not lost
            r_stage.rs1_data <= w_fwd1;
            r_stage.rs2_data <= w_fwd2;
        end else begin
            r_stage.valid     <= bus.in_valid;
            r_stage.rs1       <= bus.in_rs1;
            r_stage.rs2       <= bus.in_rs2;
            r_stage.rd        <= bus.in_rd;
            r_stage.rs1_data  <= bus.in_rs1_data;
            r_stage.rs2_data  <= bus.in_rs2_data;
            r_stage.imm       <= bus.in_imm;
            r_stage.use_imm   <= bus.in_use_imm;
            r_stage.alu_op    <= bus.in_alu_op;
            r_stage.reg_write <= bus.in_reg_write & bus.in_valid;
        end
    end

    assign bus.ex_valid      = r_stage.valid;
    assign bus.ex_rd         = r_stage.rd;
    assign bus.ex_reg_write  = r_stage.reg_write;
    assign bus.alu_op        = r_stage.valid ? r_stage.alu_op : ALU_NOP;
    assign bus.alu_a         = r_stage.valid ? w_fwd1 : '0;
    assign bus.ex_store_data = r_stage.valid ? w_fwd2 : '0;
    assign bus.alu_b         = !r_stage.valid  ? '0 :
                               r_stage.use_imm ? r_stage.imm : w_fwd2;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed scenarios plus
// randomized traffic against a behavioural pipeline-slot model.
module tb_alu_operand_stage;
    import alu_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    alu_operand_stage_if bus ();

    alu_operand_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // model of the instruction currently held by the stage
    logic            m_valid;
    logic [REGW-1:0] m_rs1, m_rs2, m_rd;
    logic [XLEN-1:0] m_d1, m_d2, m_imm;
    logic            m_use, m_rw;
    logic [3:0]      m_op;

    function automatic logic [XLEN-1:0] ref_fwd(
        input logic [REGW-1:0] rs,
        input logic [XLEN-1:0] stored
    );
        if (rs != 0 && bus.exm_reg_write && bus.exm_rd == rs)
            return bus.exm_result;
        if (rs != 0 && bus.wb_reg_write && bus.wb_rd == rs)
            return bus.wb_result;
        return stored;
    endfunction

    task automatic drive_idle();
        rst               = 1'b0;
        bus.stall         = 1'b0;
        bus.flush         = 1'b0;
        bus.in_valid      = 1'b0;
        bus.in_rs1        = '0;
        bus.in_rs2        = '0;
        bus.in_rd         = '0;
        bus.in_rs1_data   = '0;
        bus.in_rs2_data   = '0;
        bus.in_imm        = '0;
        bus.in_use_imm    = 1'b0;
        bus.in_alu_op     = 4'b0000;
        bus.in_reg_write  = 1'b0;
        bus.exm_reg_write = 1'b0;
        bus.exm_rd        = '0;
        bus.exm_result    = '0;
        bus.wb_reg_write  = 1'b0;
        bus.wb_rd         = '0;
        bus.wb_result     = '0;
    endtask

    task automatic drive_random_in(input int maxreg);
        bus.in_valid     = 1'($urandom);
        bus.in_rs1       = REGW'($urandom_range(0, maxreg));
        bus.in_rs2       = REGW'($urandom_range(0, maxreg));
        bus.in_rd        = REGW'($urandom_range(0, maxreg));
        bus.in_rs1_data  = $urandom;
        bus.in_rs2_data  = $urandom;
        bus.in_imm       = $urandom;
        bus.in_use_imm   = 1'($urandom);
        bus.in_alu_op    = 4'($urandom);
        bus.in_reg_write = 1'($urandom);
    endtask

    task automatic test_reset();
        @(negedge clk);
        drive_random_in(31);
        bus.exm_reg_write = 1'b1;
        bus.exm_rd        = 5'd0;
        bus.exm_result    = $urandom;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.ex_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid got=%b exp=0", bus.ex_valid);
        end
        checks++;
        if (bus.alu_op !== 4'b1111) begin
            failures++;
            $display("FAIL reset_op got=%h exp=f", bus.alu_op);
        end
        checks++;
        if (bus.alu_a !== 32'h0 || bus.alu_b !== 32'h0) begin
            failures++;
            $display("FAIL reset_ab got=%h/%h exp=0/0", bus.alu_a, bus.alu_b);
        end
        checks++;
        if (bus.ex_reg_write !== 1'b0 || bus.ex_rd !== 5'd0) begin
            failures++;
            $display("FAIL reset_rd got=%b/%0d exp=0/0",
                     bus.ex_reg_write, bus.ex_rd);
        end
        checks++;
        if (bus.ex_store_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_store got=%h exp=0", bus.ex_store_data);
        end
        drive_idle();
    endtask

    task automatic test_plain_load();
        @(negedge clk);
        drive_idle();
        bus.in_valid     = 1'b1;
        bus.in_rs1       = 5'd1;
        bus.in_rs2       = 5'd2;
        bus.in_rd        = 5'd4;
        bus.in_rs1_data  = 32'h0000_0007;
        bus.in_rs2_data  = 32'h0000_0099;
        bus.in_imm       = 32'hFFFF_FFFC;
        bus.in_use_imm   = 1'b1;
        bus.in_alu_op    = 4'b0100;
        bus.in_reg_write = 1'b1;
        @(negedge clk);
        drive_idle();
        bus.stall = 1'b1;
        #1;
        checks++;
        if (bus.alu_a !== 32'h7 || bus.alu_b !== 32'hFFFF_FFFC) begin
            failures++;
            $display("FAIL load_ab got=%h/%h exp=7/fffffffc",
                     bus.alu_a, bus.alu_b);
        end
        checks++;
        if (bus.alu_op !== 4'b0100 || bus.ex_valid !== 1'b1) begin
            failures++;
            $display("FAIL load_op got=%h/%b exp=4/1",
                     bus.alu_op, bus.ex_valid);
        end
        checks++;
        if (bus.ex_store_data !== 32'h99 || bus.ex_rd !== 5'd4 ||
            bus.ex_reg_write !== 1'b1) begin
            failures++;
            $display("FAIL load_store got=%h/%0d/%b exp=99/4/1",
                     bus.ex_store_data, bus.ex_rd, bus.ex_reg_write);
        end
        // reg_write must be dropped for a non-valid slot
        @(negedge clk);
        drive_idle();
        bus.in_rd        = 5'd7;
        bus.in_reg_write = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.ex_reg_write !== 1'b0 || bus.ex_valid !== 1'b0 ||
            bus.alu_op !== 4'b1111) begin
            failures++;
            $display("FAIL gate_rw got=%b/%b/%h exp=0/0/f",
                     bus.ex_reg_write, bus.ex_valid, bus.alu_op);
        end
    endtask

    task automatic test_fwd_priority();
        @(negedge clk);
        drive_idle();
        bus.in_valid    = 1'b1;
        bus.in_rs1      = 5'd5;
        bus.in_rs1_data = 32'h0000_0011;
        bus.in_rs2      = 5'd6;
        bus.in_alu_op   = 4'b0000;
        @(negedge clk);
        bus.stall         = 1'b1;
        bus.exm_reg_write = 1'b1;
        bus.exm_rd        = 5'd5;
        bus.exm_result    = 32'hAAAA_0000;
        bus.wb_reg_write  = 1'b1;
        bus.wb_rd         = 5'd5;
        bus.wb_result     = 32'h0000_1234;
        #1;
        checks++;
        if (bus.alu_a !== 32'hAAAA_0000) begin
            failures++;
            $display("FAIL fwd_exm got=%h exp=aaaa0000", bus.alu_a);
        end
        bus.exm_reg_write = 1'b0;
        #1;
        checks++;
        if (bus.alu_a !== 32'h0000_1234) begin
            failures++;
            $display("FAIL fwd_wb got=%h exp=00001234", bus.alu_a);
        end
        bus.wb_reg_write = 1'b0;
        #1;
        checks++;
        if (bus.alu_a !== 32'h0000_0011) begin
            failures++;
            $display("FAIL fwd_none got=%h exp=00000011", bus.alu_a);
        end
        drive_idle();
    endtask

    task automatic test_x0_guard();
        @(negedge clk);
        drive_idle();
        bus.in_valid  = 1'b1;
        bus.in_alu_op = 4'b0010;
        @(negedge clk);
        bus.stall         = 1'b1;
        bus.exm_reg_write = 1'b1;
        bus.exm_rd        = 5'd0;
        bus.exm_result    = 32'hDEAD_BEEF;
        bus.wb_reg_write  = 1'b1;
        bus.wb_rd         = 5'd0;
        bus.wb_result     = 32'hCAFE_F00D;
        #1;
        checks++;
        if (bus.alu_b !== 32'h0 || bus.ex_store_data !== 32'h0 ||
            bus.alu_a !== 32'h0) begin
            failures++;
            $display("FAIL x0_guard got=%h/%h/%h exp=0/0/0",
                     bus.alu_a, bus.alu_b, bus.ex_store_data);
        end
        drive_idle();
    endtask

    task automatic test_stall_refresh();
        @(negedge clk);
        drive_idle();
        bus.in_valid    = 1'b1;
        bus.in_rs1      = 5'd3;
        bus.in_rs1_data = 32'h0000_0010;
        bus.in_rd       = 5'd8;
        bus.in_alu_op   = 4'b0110;
        @(negedge clk);
        drive_idle();
        bus.stall        = 1'b1;
        bus.wb_reg_write = 1'b1;
        bus.wb_rd        = 5'd3;
        bus.wb_result    = 32'h0000_0055;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) begin
                bus.wb_reg_write = 1'b0;
                bus.wb_result    = 32'h0;
            end
            if (c == 2) bus.stall = 1'b0;
            #1;
            checks++;
            if (bus.alu_a !== 32'h55 || bus.alu_op !== 4'b0110 ||
                bus.ex_rd !== 5'd8) begin
                failures++;
                $display("FAIL stall_refresh c=%0d got=%h/%h/%0d exp=55/6/8",
                         c, bus.alu_a, bus.alu_op, bus.ex_rd);
            end
            @(negedge clk);
        end
        drive_idle();
    endtask

    task automatic test_flush_stall();
        @(negedge clk);
        drive_idle();
        bus.in_valid     = 1'b1;
        bus.in_rd        = 5'd9;
        bus.in_reg_write = 1'b1;
        bus.in_alu_op    = 4'b1000;
        @(negedge clk);
        drive_idle();
        checks++;
        if (bus.ex_valid !== 1'b1 || bus.ex_reg_write !== 1'b1) begin
            failures++;
            $display("FAIL flush_pre got=%b/%b exp=1/1",
                     bus.ex_valid, bus.ex_reg_write);
        end
        bus.flush = 1'b1;
        bus.stall = 1'b1;
        @(negedge clk);
        drive_idle();
        checks++;
        if (bus.ex_valid !== 1'b0 || bus.ex_reg_write !== 1'b0 ||
            bus.alu_op !== 4'b1111 || bus.ex_rd !== 5'd0) begin
            failures++;
            $display("FAIL flush_stall got=%b/%b/%h/%0d exp=0/0/f/0",
                     bus.ex_valid, bus.ex_reg_write, bus.alu_op, bus.ex_rd);
        end
    endtask

    task automatic test_random();
        logic [XLEN-1:0] ea, eb, es;
        logic [3:0]      eo;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            drive_random_in(3);
            rst = (n == 0) || ($urandom_range(0, 49) == 0);
            bus.flush = ($urandom_range(0, 9) == 0);
            bus.stall = ($urandom_range(0, 3) == 0);
            bus.exm_reg_write = 1'($urandom);
            bus.exm_rd        = REGW'($urandom_range(0, 3));
            bus.exm_result    = $urandom;
            bus.wb_reg_write  = 1'($urandom);
            bus.wb_rd         = REGW'($urandom_range(0, 3));
            bus.wb_result     = $urandom;
            #1;
            if (n > 0) begin
                ea = m_valid ? ref_fwd(m_rs1, m_d1) : '0;
                es = m_valid ? ref_fwd(m_rs2, m_d2) : '0;
                eb = !m_valid ? '0 : (m_use ? m_imm : ref_fwd(m_rs2, m_d2));
                eo = m_valid ? m_op : 4'b1111;
                checks++;
                if (bus.alu_a !== ea || bus.alu_b !== eb ||
                    bus.ex_store_data !== es) begin
                    failures++;
                    $display("FAIL rand_data n=%0d got=%h/%h/%h exp=%h/%h/%h",
                             n, bus.alu_a, bus.alu_b, bus.ex_store_data,
                             ea, eb, es);
                end
                checks++;
                if (bus.ex_valid !== m_valid || bus.alu_op !== eo ||
                    bus.ex_rd !== m_rd || bus.ex_reg_write !== m_rw) begin
                    failures++;
                    $display("FAIL rand_ctl n=%0d got=%b/%h/%0d/%b exp=%b/%h/%0d/%b",
                             n, bus.ex_valid, bus.alu_op, bus.ex_rd,
                             bus.ex_reg_write, m_valid, eo, m_rd, m_rw);
                end
            end
            if (rst || bus.flush) begin
                m_valid = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0;
                m_d1 = 0; m_d2 = 0; m_imm = 0; m_use = 0;
                m_op = 4'b1111; m_rw = 0;
            end else if (bus.stall) begin
                ea   = ref_fwd(m_rs1, m_d1);
                m_d2 = ref_fwd(m_rs2, m_d2);
                m_d1 = ea;
            end else begin
                m_valid = bus.in_valid;
                m_rs1   = bus.in_rs1;
                m_rs2   = bus.in_rs2;
                m_rd    = bus.in_rd;
                m_d1    = bus.in_rs1_data;
                m_d2    = bus.in_rs2_data;
                m_imm   = bus.in_imm;
                m_use   = bus.in_use_imm;
                m_op    = bus.in_alu_op;
                m_rw    = bus.in_reg_write && bus.in_valid;
            end
        end
        @(negedge clk);
        drive_idle();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        drive_idle();
        test_reset();
        test_plain_load();
        test_fwd_priority();
        test_x0_guard();
        test_stall_refresh();
        test_flush_stall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

Pipeline register and operand-forwarding stage directly upstream of the ALU. It captures decoded operands, immediate, ALU opcode and destination info from the decode stage. It resolves RAW hazards by forwarding from the EX/MEM and WB stages, and drives the ALU's `A`, `B` and `ALUOp` inputs. It supports stall (hold) and flush (bubble insertion) from the hazard unit.

## Interface
- `XLEN`, 32, datapath width
- `REGW`, 5, register index width
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `stall`  in  1  hold current contents (operands refreshed, see Operation)
- `flush`  in  1  load a bubble on next edge
- `in_valid`  in  1  decode slot holds a real instruction
- `in_rs1`, `in_rs2`, `in_rd`  in  REGW each  source/destination indices
- `in_rs1_data`, `in_rs2_data`  in  XLEN each  register-file read data
- `in_imm`  in  XLEN  sign-extended immediate
- `in_use_imm`  in  1  B operand comes from immediate
- `in_alu_op`  in  4  ALU opcode
- `in_reg_write`  in  1  instruction writes `rd`
- `exm_reg_write`, `exm_rd`, `exm_result`  in  1/REGW/XLEN  EX/MEM forwarding source
- `wb_reg_write`, `wb_rd`, `wb_result`  in  1/REGW/XLEN  WB forwarding source
- `ex_valid`  out  1  stage holds a real instruction
- `alu_a`, `alu_b`  out  XLEN each  ALU operands
- `alu_op`  out  4  ALU opcode
- `ex_rd`  out  REGW  destination index
- `ex_reg_write`  out  1  gated by `ex_valid`
- `ex_store_data`  out  XLEN  forwarded rs2 value, always (ignores `in_use_imm`)

## Operation
- Stored fields: valid, rs1, rs2, rd, rs1_data, rs2_data, imm, use_imm, alu_op, reg_write.
- Edge priority, highest first: `rst` > `flush` > `stall` > load.
  - `rst` or `flush`: bubble. valid=0, reg_write=0, alu_op=ALU_NOP (4'b1111; ALU default gives Result 0). All indices and data are 0.
  - `stall` (no flush): control fields and indices hold. rs1_data/rs2_data are overwritten with the current forwarded values, so a producer retiring from WB during the stall is not lost.
  - Otherwise: load all fields from `in_*`. `reg_write` is loaded as `in_reg_write & in_valid`.
- Forwarding, combinational, per source operand `rsX`. Highest priority wins:
  1. `exm_reg_write && exm_rd == rsX && rsX != 0` → `exm_result`
  2. `wb_reg_write && wb_rd == rsX && rsX != 0` → `wb_result`
  3. Otherwise → stored rsX_data
- `rsX == 0` never forwards; stored data is passed through as-is.
- Output drive:
  - `alu_a` = fwd(rs1).
  - `alu_b` = imm when use_imm, else fwd(rs2).
  - `ex_store_data` = fwd(rs2).
- When `ex_valid`=0, `alu_a`, `alu_b` and `ex_store_data` are forced to 0 and `alu_op` = ALU_NOP.
- `ex_rd` and `ex_reg_write` come straight from the register.
- No arithmetic in this block. All datapaths are XLEN wide with no extension or truncation.

## Timing
- Latency: 1 cycle from `in_*` to registered fields. Forwarding muxes are combinational after the register, in the same cycle as the ALU.
- Reset values:
  - `ex_valid`=0, `ex_reg_write`=0, `ex_rd`=0
  - `alu_op`=4'b1111
  - `alu_a`=`alu_b`=`ex_store_data`=0
- `stall` and `flush` are sampled on the same edge as `in_*`. `flush`+`stall` together gives a bubble.
- A stall of N cycles holds `alu_op`/`ex_rd` for N+1 visible cycles. Operand values may change during the stall as forwarding sources update; that is the required behaviour.
- `rst` asserted mid-stream discards the held instruction on the next edge. No partial state survives.
- No combinational path from `stall`/`flush` to outputs.

## Structure
- Shared package `alu_pkg` holds:
  - `XLEN`
  - ALU opcode constants: ALU_MUL=0000, ALU_DIV=0001, ALU_OR=0010/0011, ALU_XOR=0100, ALU_SLL=0101, ALU_SRL=0110, ALU_SRA=0111, ALU_SLT=1000, ALU_SLTU=1001, ALU_NOP=1111
  - A typedef for the stage payload struct
- One sub-module, `operand_fwd_mux`, instantiated twice (rs1, rs2). It takes the index, stored data and both forwarding sources, and returns the forwarded value.

## Test plan
- Reset: hold `rst` 2 cycles with random `in_*` → `ex_valid`=0, `alu_op`=4'b1111, `alu_a`=`alu_b`=0, `ex_reg_write`=0.
- Plain load: rs1_data=0x0000_0007, use_imm=1, imm=0xFFFF_FFFC, op=0100 → next cycle `alu_a`=7, `alu_b`=0xFFFF_FFFC, `alu_op`=0100, `ex_valid`=1.
- Forward priority: rs1=5, `exm_rd`=5/`exm_result`=0xAAAA_0000, `wb_rd`=5/`wb_result`=0x1234 → `alu_a`=0xAAAA_0000. Then drop `exm_reg_write` → `alu_a`=0x1234.
- x0 guard: rs2=0, stored 0, `exm_rd`=0, `exm_reg_write`=1, `exm_result`=0xDEAD_BEEF → `alu_b`=0.
- Stall refresh: stall 2 cycles on rs1=3 while `wb_rd`=3, `wb_result`=0x55 is present only in the first cycle → `alu_a` still 0x55 after the WB source leaves. `alu_op` is unchanged throughout.
- Flush vs. stall: assert both with a valid instruction held → next cycle `ex_valid`=0, `ex_reg_write`=0, `alu_op`=4'b1111.
